temp_seg_display: RTL

// Consumes the 8-bit signed Celsius byte from the LM75A I2C reader and shows it on a 4-digit multiplexed 7-seg display.
// - Change detect captures the new value; sequential double-dabble converts it to sign + 3 BCD digits.
// - A scan counter time-multiplexes the digits. Sits between the sensor reader and the board display pins.

---
 rtl/temp_seg_display.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/temp_seg_display.sv
// Signed LM75A byte -> sign + 3 BCD digits (sequential double-dabble), shown on a 4-digit muxed 7-seg.
// Define TEMP_SEG_LZB_EN for leading-zero blanking of hundreds/tens.
module temp_seg_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] temp_data,
  input  logic       sensor_ok,
  output logic [6:0] seg_n,
  output logic [3:0] dig_n,
  output logic       busy
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

  state_t      r_state, w_next;
  logic [7:0]  r_cap;
  logic [7:0]  r_mag;
  logic [9:0]  r_bcd;
  logic        r_sign_w;
  logic [2:0]  r_bit;
  logic        r_busy;
  logic [3:0]  r_hun, r_ten, r_uni;
  logic        r_sign;
  logic [CW-1:0] r_cnt;
  logic [1:0]  r_idx;
  logic [6:0]  r_seg;
  logic [3:0]  r_dig;

  logic [7:0]  w_abs;
  logic [7:0]  w_adj;
  logic [6:0]  w_seg;
  logic [3:0]  w_dig;
  logic        w_blank_h, w_blank_t;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return SEG_BLANK;
    endcase
  endfunction

  // -128 negates to 8'h80, which read unsigned is the correct magnitude 128.
  assign w_abs = temp_data[7] ? (~temp_data + 8'd1) : temp_data;
  // Hundreds never exceeds 1 (|v| <= 128), so it needs only 2 bits and no add-3.
  assign w_adj = {add3(r_bcd[7:4]), add3(r_bcd[3:0])};

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (temp_data != r_cap) w_next = LOAD;
      LOAD:    w_next = SHIFT;
      SHIFT:   if (r_bit == 3'd7) w_next = COMMIT;
      COMMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cap    <= '0;
      r_mag    <= '0;
      r_bcd    <= '0;
      r_sign_w <= 1'b0;
      r_bit    <= '0;
      r_busy   <= 1'b0;
      r_hun    <= '0;
      r_ten    <= '0;
      r_uni    <= '0;
      r_sign   <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          r_cap    <= temp_data;
          r_mag    <= w_abs;
          r_bcd    <= '0;
          r_sign_w <= temp_data[7];
          r_bit    <= '0;
          r_busy   <= 1'b1;
        end
        SHIFT: begin
          r_bcd <= {r_bcd[8], w_adj, r_mag[7]};
          r_mag <= {r_mag[6:0], 1'b0};
          r_bit <= r_bit + 3'd1;
        end
        COMMIT: begin
          r_hun  <= {2'b00, r_bcd[9:8]};
          r_ten  <= r_bcd[7:4];
          r_uni  <= r_bcd[3:0];
          r_sign <= r_sign_w;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef TEMP_SEG_LZB_EN
  assign w_blank_h = (r_hun == 4'd0);
  assign w_blank_t = (r_hun == 4'd0) && (r_ten == 4'd0);
`else
  assign w_blank_h = 1'b0;
  assign w_blank_t = 1'b0;
`endif

  always_comb begin
    w_seg = SEG_BLANK;
    case (r_idx)
      2'd3: w_seg = r_sign ? SEG_DASH : SEG_BLANK;
      2'd2: w_seg = w_blank_h ? SEG_BLANK : enc(r_hun);
      2'd1: w_seg = w_blank_t ? SEG_BLANK : enc(r_ten);
      2'd0: w_seg = enc(r_uni);
      default: ;
    endcase
    if (!sensor_ok) w_seg = SEG_DASH;
  end

  assign w_dig = ~(4'b0001 << r_idx);

  // At each wrap the outputs take the digit for the current index, then the index advances,
  // so the first wrap after reset lights digit 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_seg <= SEG_BLANK;
      r_dig <= 4'hF;
    end else if (r_cnt == CW'(SCAN_DIV - 1)) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
      r_seg <= w_seg;
      r_dig <= w_dig;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign seg_n = r_seg;
  assign dig_n = r_dig;
  assign busy  = r_busy;

endmodule
